// File: rtl/vc_proc_net_adapter_ordered.sv
// Processor-side net adapter: wraps memreq into {dest,src,payload} and returns responses in request order.
// Optional performance counters are enabled by defining VC_PROC_NET_ADAPTER_PERF_EN.
module vc_proc_net_adapter_ordered #(
  parameter int p_router_id    = 0,
  parameter int p_num_nodes    = 4,
  parameter int p_addr_sz      = 8,
  parameter int p_data_sz      = 32,
  parameter int p_max_requests = 8,
  parameter int p_dest_mode    = 1,
  parameter int p_dest_offset  = 4,
  parameter int p_fixed_dest   = 0,
  localparam int c_srcdest_sz     = (p_num_nodes > 1) ? $clog2(p_num_nodes) : 1,
  localparam int c_memreq_msg_sz  = 1 + p_addr_sz + p_data_sz,
  localparam int c_memresp_msg_sz = 1 + p_data_sz,
  localparam int c_reqnet_msg_sz  = 2 * c_srcdest_sz + c_memreq_msg_sz,
  localparam int c_respnet_msg_sz = 2 * c_srcdest_sz + c_memresp_msg_sz,
  localparam int c_req_count_sz   = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [c_memreq_msg_sz-1:0]  memreq_msg,
  input  logic                        memreq_val,
  output logic                        memreq_rdy,
  output logic [c_reqnet_msg_sz-1:0]  netin_msg,
  output logic                        netin_val,
  input  logic                        netin_rdy,
  input  logic [c_respnet_msg_sz-1:0] netout_msg,
  input  logic                        netout_val,
  output logic                        netout_rdy,
  output logic [c_memresp_msg_sz-1:0] memresp_msg,
  output logic                        memresp_val,
  input  logic                        memresp_rdy,
  output logic [c_req_count_sz-1:0]   inflight
`ifdef VC_PROC_NET_ADAPTER_PERF_EN
  ,
  output logic [31:0]                 perf_reqs,
  output logic [31:0]                 perf_full_stall,
  output logic [31:0]                 perf_order_stall
`endif
);

  localparam int c_ptr_sz = (p_max_requests > 1) ? $clog2(p_max_requests) : 1;
  localparam logic [c_ptr_sz-1:0]       c_last_ptr  = c_ptr_sz'(p_max_requests - 1);
  localparam logic [c_ptr_sz-1:0]       c_ptr_one   = c_ptr_sz'(1);
  localparam logic [c_req_count_sz-1:0] c_max_count = c_req_count_sz'(p_max_requests);
  localparam logic [c_srcdest_sz-1:0]   c_src_id    = c_srcdest_sz'(p_router_id);

  logic [c_srcdest_sz-1:0]   dest_fifo [p_max_requests];
  logic [c_ptr_sz-1:0]       wr_ptr;
  logic [c_ptr_sz-1:0]       rd_ptr;
  logic [c_req_count_sz-1:0] count;

  logic                      empty;
  logic                      full;
  logic                      head_match;
  logic                      can_issue;
  logic                      req_fire;
  logic                      resp_fire;
  logic [p_addr_sz-1:0]      req_addr;
  logic [c_srcdest_sz-1:0]   req_dest;
  logic [c_srcdest_sz-1:0]   resp_src;

  assign req_addr = memreq_msg[p_data_sz +: p_addr_sz];
  assign resp_src = netout_msg[c_memresp_msg_sz +: c_srcdest_sz];

  // Address-to-bank mapping chosen at elaboration so unused slices are never built.
  generate
    if (p_dest_mode == 0) begin : g_dest_fixed
      assign req_dest = c_srcdest_sz'(p_fixed_dest);
    end else if (p_dest_mode == 2) begin : g_dest_hash
      assign req_dest = req_addr[p_dest_offset +: c_srcdest_sz]
                      ^ req_addr[p_dest_offset + c_srcdest_sz +: c_srcdest_sz];
    end else begin : g_dest_field
      assign req_dest = req_addr[p_dest_offset +: c_srcdest_sz];
    end
  endgenerate

  assign empty      = (count == '0);
  assign full       = (count == c_max_count);
  assign head_match = !empty && (resp_src == dest_fifo[rd_ptr]);

  // Response side depends only on the head entry, so netout_rdy never sees request-side inputs.
  assign memresp_val = netout_val && head_match;
  assign netout_rdy  = memresp_rdy && head_match;
  assign resp_fire   = netout_val && netout_rdy;
  assign memresp_msg = netout_msg[c_memresp_msg_sz-1:0];

  assign can_issue  = !full || resp_fire;
  assign netin_val  = memreq_val && can_issue;
  assign memreq_rdy = netin_rdy && can_issue;
  assign req_fire   = netin_val && netin_rdy;
  assign netin_msg  = {req_dest, c_src_id, memreq_msg};
  assign inflight   = count;

  // Destination storage; contents are only meaningful between wr_ptr and rd_ptr.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      dest_fifo[wr_ptr] <= req_dest;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (req_fire) begin
        wr_ptr <= (wr_ptr == c_last_ptr) ? '0 : wr_ptr + c_ptr_one;
      end
      if (resp_fire) begin
        rd_ptr <= (rd_ptr == c_last_ptr) ? '0 : rd_ptr + c_ptr_one;
      end
      if (req_fire && !resp_fire) begin
        count <= count + 6'd1;
      end else if (!req_fire && resp_fire) begin
        count <= count - 6'd1;
      end else begin
        count <= count;
      end
    end
  end

`ifdef VC_PROC_NET_ADAPTER_PERF_EN
  // Event counters for issued requests and the two stall causes.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reqs        <= 32'd0;
      perf_full_stall  <= 32'd0;
      perf_order_stall <= 32'd0;
    end else begin
      if (req_fire) begin
        perf_reqs <= perf_reqs + 32'd1;
      end
      if (memreq_val && full && !resp_fire) begin
        perf_full_stall <= perf_full_stall + 32'd1;
      end
      if (netout_val && !empty && !head_match) begin
        perf_order_stall <= perf_order_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_proc_net_adapter_ordered.sv
// Bench for vc_proc_net_adapter_ordered: mapping table, directed ordering sequences, and a
// randomized run against a queue-based reference model.
module tb_vc_proc_net_adapter_ordered;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Main instance: mode 1, 8 in flight, router id 1.
  logic [40:0] a_req_msg;   logic a_req_val, a_req_rdy;
  logic [44:0] a_netin_msg; logic a_netin_val, a_netin_rdy;
  logic [36:0] a_netout_msg; logic a_netout_val, a_netout_rdy;
  logic [32:0] a_resp_msg;  logic a_resp_val, a_resp_rdy;
  logic [5:0]  a_inflight;
  // Small instance: 2 in flight, router id 2.
  logic [40:0] b_req_msg;   logic b_req_val, b_req_rdy;
  logic [44:0] b_netin_msg; logic b_netin_val, b_netin_rdy;
  logic [36:0] b_netout_msg; logic b_netout_val, b_netout_rdy;
  logic [32:0] b_resp_msg;  logic b_resp_val, b_resp_rdy;
  logic [5:0]  b_inflight;
  // Mapping-only instances (hash mode and fixed mode) share the main inputs.
  logic c_req_rdy, c_netin_val, c_netout_rdy, c_resp_val, d_req_rdy, d_netin_val, d_netout_rdy, d_resp_val;
  logic [44:0] c_netin_msg, d_netin_msg;
  logic [32:0] c_resp_msg, d_resp_msg;
  logic [5:0]  c_inflight, d_inflight;
`ifdef VC_PROC_NET_ADAPTER_PERF_EN
  logic [31:0] a_perf_reqs, a_perf_full, a_perf_order, b_perf_reqs, b_perf_full, b_perf_order;
  logic [31:0] c_perf_reqs, c_perf_full, c_perf_order, d_perf_reqs, d_perf_full, d_perf_order;
`endif

  vc_proc_net_adapter_ordered #(.p_router_id(1), .p_max_requests(8), .p_dest_mode(1)) dut_a (
    .clk(clk), .reset(reset), .memreq_msg(a_req_msg), .memreq_val(a_req_val), .memreq_rdy(a_req_rdy),
    .netin_msg(a_netin_msg), .netin_val(a_netin_val), .netin_rdy(a_netin_rdy),
    .netout_msg(a_netout_msg), .netout_val(a_netout_val), .netout_rdy(a_netout_rdy),
    .memresp_msg(a_resp_msg), .memresp_val(a_resp_val), .memresp_rdy(a_resp_rdy), .inflight(a_inflight)
`ifdef VC_PROC_NET_ADAPTER_PERF_EN
    , .perf_reqs(a_perf_reqs), .perf_full_stall(a_perf_full), .perf_order_stall(a_perf_order)
`endif
  );

  vc_proc_net_adapter_ordered #(.p_router_id(2), .p_max_requests(2), .p_dest_mode(1)) dut_b (
    .clk(clk), .reset(reset), .memreq_msg(b_req_msg), .memreq_val(b_req_val), .memreq_rdy(b_req_rdy),
    .netin_msg(b_netin_msg), .netin_val(b_netin_val), .netin_rdy(b_netin_rdy),
    .netout_msg(b_netout_msg), .netout_val(b_netout_val), .netout_rdy(b_netout_rdy),
    .memresp_msg(b_resp_msg), .memresp_val(b_resp_val), .memresp_rdy(b_resp_rdy), .inflight(b_inflight)
`ifdef VC_PROC_NET_ADAPTER_PERF_EN
    , .perf_reqs(b_perf_reqs), .perf_full_stall(b_perf_full), .perf_order_stall(b_perf_order)
`endif
  );

  vc_proc_net_adapter_ordered #(.p_router_id(0), .p_dest_mode(2), .p_dest_offset(4)) dut_c (
    .clk(clk), .reset(reset), .memreq_msg(a_req_msg), .memreq_val(a_req_val), .memreq_rdy(c_req_rdy),
    .netin_msg(c_netin_msg), .netin_val(c_netin_val), .netin_rdy(a_netin_rdy),
    .netout_msg(a_netout_msg), .netout_val(a_netout_val), .netout_rdy(c_netout_rdy),
    .memresp_msg(c_resp_msg), .memresp_val(c_resp_val), .memresp_rdy(a_resp_rdy), .inflight(c_inflight)
`ifdef VC_PROC_NET_ADAPTER_PERF_EN
    , .perf_reqs(c_perf_reqs), .perf_full_stall(c_perf_full), .perf_order_stall(c_perf_order)
`endif
  );

  vc_proc_net_adapter_ordered #(.p_router_id(3), .p_dest_mode(0), .p_fixed_dest(2)) dut_d (
    .clk(clk), .reset(reset), .memreq_msg(a_req_msg), .memreq_val(a_req_val), .memreq_rdy(d_req_rdy),
    .netin_msg(d_netin_msg), .netin_val(d_netin_val), .netin_rdy(a_netin_rdy),
    .netout_msg(a_netout_msg), .netout_val(a_netout_val), .netout_rdy(d_netout_rdy),
    .memresp_msg(d_resp_msg), .memresp_val(d_resp_val), .memresp_rdy(a_resp_rdy), .inflight(d_inflight)
`ifdef VC_PROC_NET_ADAPTER_PERF_EN
    , .perf_reqs(d_perf_reqs), .perf_full_stall(d_perf_full), .perf_order_stall(d_perf_order)
`endif
  );

  typedef struct {
    logic [7:0] addr;
    logic [1:0] dest_field;
    logic [1:0] dest_hash;
  } map_vec_t;

  function automatic logic [40:0] mk_req(input logic [7:0] addr, input logic [31:0] data);
    return {1'b0, addr, data};
  endfunction

  function automatic logic [36:0] mk_resp(input logic [1:0] dest, input logic [1:0] src, input logic [31:0] data);
    return {dest, src, 1'b0, data};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_req_val = 1'b0; a_req_msg = '0; a_netin_rdy = 1'b1;
    a_netout_val = 1'b0; a_netout_msg = '0; a_resp_rdy = 1'b1;
    b_req_val = 1'b0; b_req_msg = '0; b_netin_rdy = 1'b1;
    b_netout_val = 1'b0; b_netout_msg = '0; b_resp_rdy = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One main-instance request cycle that fires; leaves the bench at the next negedge.
  task automatic a_issue(input logic [7:0] addr);
    a_req_val = 1'b1; a_req_msg = mk_req(addr, 32'h1000 + 32'(addr));
    @(negedge clk);
    a_req_val = 1'b0;
  endtask

  map_vec_t map_tbl [8];
  logic [1:0] model_q [$];

  initial begin
    reset = 1'b1;
    idle_inputs();
    map_tbl[0] = '{8'h30, 2'd3, 2'd3};
    map_tbl[1] = '{8'h5C, 2'd1, 2'd0};
    map_tbl[2] = '{8'h00, 2'd0, 2'd0};
    map_tbl[3] = '{8'hFF, 2'd3, 2'd0};
    map_tbl[4] = '{8'h9B, 2'd1, 2'd3};
    map_tbl[5] = '{8'h6E, 2'd2, 2'd3};
    map_tbl[6] = '{8'h4A, 2'd0, 2'd1};
    map_tbl[7] = '{8'hA7, 2'd2, 2'd0};

    // Reset state, with a stale response presented while empty.
    do_reset();
    a_netout_val = 1'b1; a_netout_msg = mk_resp(2'd1, 2'd0, 32'h0);
    #1;
    chk("rst_inflight", a_inflight, 0);
    chk("rst_netout_rdy", a_netout_rdy, 0);
    chk("rst_memresp_val", a_resp_val, 0);
    chk("rst_memreq_rdy", a_req_rdy, 1);
    @(negedge clk);
    a_netout_val = 1'b0;

    // Address mapping table: netin_rdy low so nothing issues.
    a_netin_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_req_val = 1'b1; a_req_msg = mk_req(map_tbl[i].addr, 32'hA5A5_0000 + 32'(i));
      #1;
      chk("map_field_dest", a_netin_msg[44:43], map_tbl[i].dest_field);
      chk("map_hash_dest", c_netin_msg[44:43], map_tbl[i].dest_hash);
      chk("map_fixed_dest", d_netin_msg[44:43], 2'd2);
      chk("map_fixed_src", d_netin_msg[42:41], 2'd3);
      chk("map_val_no_rdy", a_netin_val, 1);
      chk("map_memreq_rdy", a_req_rdy, 0);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("map_no_issue", a_inflight, 0);

    // Single round trip to bank 3.
    do_reset();
    a_req_val = 1'b1; a_req_msg = mk_req(8'h30, 32'h1234_5678);
    #1;
    chk("t1_netin_val", a_netin_val, 1);
    chk("t1_netin_msg", a_netin_msg, {2'd3, 2'd1, mk_req(8'h30, 32'h1234_5678)});
    @(negedge clk);
    a_req_val = 1'b0;
    a_netout_val = 1'b1; a_netout_msg = mk_resp(2'd1, 2'd3, 32'hCAFE_F00D);
    #1;
    chk("t1_inflight1", a_inflight, 1);
    chk("t1_memresp_val", a_resp_val, 1);
    chk("t1_netout_rdy", a_netout_rdy, 1);
    chk("t1_memresp_msg", a_resp_msg, {1'b0, 32'hCAFE_F00D});
    @(negedge clk);
    a_netout_val = 1'b0;
    #1;
    chk("t1_inflight0", a_inflight, 0);

    // Cap of 2: third request stalls until a same-cycle response frees a slot.
    do_reset();
    b_req_val = 1'b1; b_req_msg = mk_req(8'h10, 32'h1);
    @(negedge clk);
    b_req_msg = mk_req(8'h20, 32'h2);
    @(negedge clk);
    b_req_msg = mk_req(8'h30, 32'h3);
    #1;
    chk("t2_inflight_full", b_inflight, 2);
    chk("t2_memreq_rdy_full", b_req_rdy, 0);
    chk("t2_netin_val_full", b_netin_val, 0);
    b_netout_val = 1'b1; b_netout_msg = mk_resp(2'd2, 2'd1, 32'h11);
    #1;
    chk("t2_memreq_rdy_pass", b_req_rdy, 1);
    chk("t2_netin_val_pass", b_netin_val, 1);
    chk("t2_netout_rdy", b_netout_rdy, 1);
    chk("t2_netin_msg", b_netin_msg, {2'd3, 2'd2, mk_req(8'h30, 32'h3)});
    @(negedge clk);
    b_req_val = 1'b0;
    b_netout_msg = mk_resp(2'd2, 2'd3, 32'h33);
    #1;
    chk("t2_inflight_stays", b_inflight, 2);
    chk("t2_not_head", b_netout_rdy, 0);
    b_netout_msg = mk_resp(2'd2, 2'd2, 32'h22);
    #1;
    chk("t2_head_bank2", b_resp_val, 1);
    @(negedge clk);
    b_netout_val = 1'b0;

    // Out-of-order replies are held back until the head bank answers.
    do_reset();
    a_issue(8'h20);
    a_issue(8'h00);
    a_netout_val = 1'b1; a_netout_msg = mk_resp(2'd1, 2'd0, 32'hB0);
    #1;
    chk("t3_inflight2", a_inflight, 2);
    chk("t3_hold_rdy", a_netout_rdy, 0);
    chk("t3_hold_val", a_resp_val, 0);
    @(negedge clk);
    a_netout_msg = mk_resp(2'd1, 2'd2, 32'hB2);
    #1;
    chk("t3_b2_val", a_resp_val, 1);
    chk("t3_b2_msg", a_resp_msg, {1'b0, 32'hB2});
    @(negedge clk);
    a_netout_msg = mk_resp(2'd1, 2'd0, 32'hB0);
    #1;
    chk("t3_b0_val", a_resp_val, 1);
    chk("t3_inflight1", a_inflight, 1);
    @(negedge clk);
    a_netout_val = 1'b0;
    #1;
    chk("t3_inflight0", a_inflight, 0);

    // Processor back-pressure: head matches but nothing pops.
    do_reset();
    a_issue(8'h10);
    a_netout_val = 1'b1; a_netout_msg = mk_resp(2'd1, 2'd1, 32'hD1); a_resp_rdy = 1'b0;
    #1;
    chk("t4_netout_rdy", a_netout_rdy, 0);
    chk("t4_memresp_val", a_resp_val, 1);
    @(negedge clk);
    #1;
    chk("t4_no_pop", a_inflight, 1);
    a_resp_rdy = 1'b1;
    #1;
    chk("t4_release", a_netout_rdy, 1);
    @(negedge clk);
    a_netout_val = 1'b0;
    #1;
    chk("t4_drained", a_inflight, 0);

    // Reset mid-operation flushes tracking.
    do_reset();
    a_issue(8'h10);
    a_issue(8'h20);
    a_issue(8'h30);
    #1;
    chk("t6_inflight3", a_inflight, 3);
    reset = 1'b1;
    a_netout_val = 1'b1; a_netout_msg = mk_resp(2'd1, 2'd1, 32'hEE);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_inflight0", a_inflight, 0);
    chk("t6_stale_rdy", a_netout_rdy, 0);
    chk("t6_stale_val", a_resp_val, 0);
`ifdef VC_PROC_NET_ADAPTER_PERF_EN
    chk("t6_perf_reqs", a_perf_reqs, 0);
    chk("t6_perf_full", a_perf_full, 0);
    chk("t6_perf_order", a_perf_order, 0);
`endif
    @(negedge clk);
    a_netout_val = 1'b0;

    // Randomized traffic against an in-order queue model of the bank sequence.
    do_reset();
    model_q.delete();
    begin
      int n_req = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic mv, nr, ov, rr, hm, rf, ci, e_nv, e_qr, e_rv, e_or, ef;
        logic [7:0] addr;
        logic [31:0] data;
        logic [1:0] src;
        mv   = ($urandom_range(0, 3) != 0);
        nr   = ($urandom_range(0, 3) != 0);
        ov   = (cyc < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
        rr   = ($urandom_range(0, 4) != 0);
        addr = 8'($urandom);
        data = $urandom;
        if (model_q.size() > 0 && $urandom_range(0, 3) != 0) src = model_q[0];
        else src = 2'($urandom_range(0, 3));

        hm   = (model_q.size() > 0) && (src == model_q[0]);
        e_rv = ov && hm;
        e_or = rr && hm;
        rf   = ov && e_or;
        ci   = (model_q.size() < 8) || rf;
        e_nv = mv && ci;
        e_qr = nr && ci;
        ef   = e_nv && nr;

        a_req_val = mv; a_req_msg = mk_req(addr, data); a_netin_rdy = nr;
        a_netout_val = ov; a_netout_msg = mk_resp(2'd1, src, ~data); a_resp_rdy = rr;
        #1;
        chk("rnd_inflight", a_inflight, 64'(model_q.size()));
        chk("rnd_netin_val", a_netin_val, e_nv);
        chk("rnd_memreq_rdy", a_req_rdy, e_qr);
        chk("rnd_netout_rdy", a_netout_rdy, e_or);
        chk("rnd_memresp_val", a_resp_val, e_rv);
        if (e_nv) chk("rnd_netin_msg", a_netin_msg, {addr[5:4], 2'd1, mk_req(addr, data)});
        if (e_rv) chk("rnd_memresp_msg", a_resp_msg, {1'b0, ~data});
        if (rf) void'(model_q.pop_front());
        if (ef) begin
          model_q.push_back(addr[5:4]);
          n_req++;
        end
        @(negedge clk);
      end
      idle_inputs();
      #1;
      chk("rnd_final_inflight", a_inflight, 64'(model_q.size()));
`ifdef VC_PROC_NET_ADAPTER_PERF_EN
      chk("rnd_perf_reqs", a_perf_reqs, 64'(n_req));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
